lsu_bus_ctrl: RTL and testbench

- Parametrised successor load/store unit between EXU and WBU.
- Replaces direct DPI memory calls with a valid/ready request channel and a valid/ready response channel, so memory latency can vary.
- Adds backpressure from WBU, byte/half/word store strobes, load sign/zero extension, misalignment detection, bus-error reporting and a response timeout.
- Carries an opaque sideband bundle (pc, rd, csr fields, ...) from EXU to WBU unchanged.

---
 rtl/lsu_bus_ctrl_pkg.sv | 46 ++++
 rtl/lsu_bus_ctrl_if.sv | 53 +++++
 rtl/lsu_bus_ctrl_data_align.sv | 55 +++++
 rtl/lsu_bus_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared types and constants for the load/store bus controller.
package lsu_pkg;

  // Transaction FSM states
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } state_e;

  // Access size decoded from func3[1:0]
  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // RV32 load func3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32 store func3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Exception cause codes reported to WBU
  localparam logic [1:0] CAUSE_NONE         = 2'd0;
  localparam logic [1:0] CAUSE_LD_MISALIGN  = 2'd1;
  localparam logic [1:0] CAUSE_ST_MISALIGN  = 2'd2;
  localparam logic [1:0] CAUSE_ACCESS_FAULT = 2'd3;

  // Undefined size encodings (x11) fall back to a word access
  function automatic size_e decodeSize(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// EXU, WBU and memory-side handshake bundle of the load/store unit.
// master is the LSU's own view; slave is the view of its surroundings.
interface lsu_bus_ctrl_if #(
  parameter int SB_W = 128
);

  logic            in_valid;
  logic            in_ready;
  logic            in_mem_ren;
  logic            in_mem_wen;
  logic [2:0]      in_func3;
  logic [31:0]     in_addr;
  logic [31:0]     in_wdata;
  logic [SB_W-1:0] in_sb;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_rdata;
  logic [SB_W-1:0] out_sb;
  logic            out_err;
  logic [1:0]      out_cause;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [31:0]     mem_req_addr;
  logic            mem_req_we;
  logic [31:0]     mem_req_wdata;
  logic [3:0]      mem_req_wstrb;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_rdata;
  logic            mem_rsp_err;

  modport master (
    input  in_valid, in_mem_ren, in_mem_wen, in_func3, in_addr, in_wdata, in_sb,
    output in_ready,
    output out_valid, out_rdata, out_sb, out_err, out_cause,
    input  out_ready,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    output in_valid, in_mem_ren, in_mem_wen, in_func3, in_addr, in_wdata, in_sb,
    input  in_ready,
    input  out_valid, out_rdata, out_sb, out_err, out_cause,
    output out_ready,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

endinterface

// File: rtl/lsu_bus_ctrl_data_align.sv
// Byte-lane datapath: misalignment check and store lane generation on the
// incoming instruction, load lane extraction and extension on the captured one.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_func3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic        misalign_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_func3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  size_e       stSize;
  size_e       ldSize;
  logic [31:0] shifted;

  // Store side: replicate data across lanes and build the byte strobe
  always_comb begin
    stSize     = decodeSize(st_func3_i);
    misalign_o = 1'b0;
    wstrb_o    = 4'b1111;
    wdata_o    = st_wdata_i;
    case (stSize)
      SZ_BYTE: begin
        wstrb_o = 4'b0001 << st_addr_lo_i;
        wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        misalign_o = st_addr_lo_i[0];
        wstrb_o    = 4'b0011 << st_addr_lo_i;
        wdata_o    = {2{st_wdata_i[15:0]}};
      end
      default: begin
        misalign_o = (st_addr_lo_i != 2'b00);
      end
    endcase
  end

  // Load side: shift the addressed lane down, then sign- or zero-extend
  always_comb begin
    ldSize  = decodeSize(ld_func3_i);
    shifted = rdata_i >> {ld_addr_lo_i, 3'b000};
    case (ldSize)
      SZ_BYTE: ld_data_o = {{24{~ld_func3_i[2] & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data_o = {{16{~ld_func3_i[2] & shifted[15]}}, shifted[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit between EXU and WBU: one instruction in flight, a
// valid/ready memory request/response pair and a bounded response wait.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int SB_W        = 128,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic               clk,
  input  logic               rst,
  lsu_bus_ctrl_if.master     bus
);

  state_e          state_q;
  logic [2:0]      func3_q;
  logic [1:0]      addr_lo_q;
  logic            is_store_q;
  logic [SB_W-1:0] sb_q;
  logic [CNT_W-1:0] cnt_q;

  logic            in_ready_q;
  logic            out_valid_q;
  logic [31:0]     out_rdata_q;
  logic            out_err_q;
  logic [1:0]      out_cause_q;

  logic            req_valid_q;
  logic [31:0]     req_addr_q;
  logic            req_we_q;
  logic [31:0]     req_wdata_q;
  logic [3:0]      req_wstrb_q;

  logic            misalign;
  logic [3:0]      laneWstrb;
  logic [31:0]     laneWdata;
  logic [31:0]     ldData;

  logic            isMemIn;
  logic            isStoreIn;
  logic [CNT_W-1:0] cnt_d;
  logic            timeoutHit;
  logic [1:0]      rsp_cause_d;
  logic [31:0]     rsp_rdata_d;

  lsu_data_align u_align (
    .st_func3_i   (bus.in_func3),
    .st_addr_lo_i (bus.in_addr[1:0]),
    .st_wdata_i   (bus.in_wdata),
    .misalign_o   (misalign),
    .wstrb_o      (laneWstrb),
    .wdata_o      (laneWdata),
    .ld_func3_i   (func3_q),
    .ld_addr_lo_i (addr_lo_q),
    .rdata_i      (bus.mem_rsp_rdata),
    .ld_data_o    (ldData)
  );

  // Decode the incoming op and pre-compute the values a response would commit
  always_comb begin
    isStoreIn   = bus.in_mem_wen;
    isMemIn     = bus.in_mem_wen | bus.in_mem_ren;
    cnt_d       = cnt_q + 1'b1;
    timeoutHit  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    rsp_cause_d = bus.mem_rsp_err ? CAUSE_ACCESS_FAULT : CAUSE_NONE;
    rsp_rdata_d = (bus.mem_rsp_err || is_store_q) ? 32'h0 : ldData;
  end

  // Transaction FSM with capture registers, timeout counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      func3_q     <= '0;
      addr_lo_q   <= '0;
      is_store_q  <= 1'b0;
      sb_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_rdata_q <= '0;
      out_err_q   <= 1'b0;
      out_cause_q <= CAUSE_NONE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            func3_q     <= bus.in_func3;
            addr_lo_q   <= bus.in_addr[1:0];
            is_store_q  <= isStoreIn;
            sb_q        <= bus.in_sb;
            in_ready_q  <= 1'b0;
            out_rdata_q <= '0;
            out_err_q   <= 1'b0;
            out_cause_q <= CAUSE_NONE;
            if (!isMemIn) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else if (misalign) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
              out_cause_q <= isStoreIn ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
            end else begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= {bus.in_addr[31:2], 2'b00};
              req_we_q    <= isStoreIn;
              req_wdata_q <= isStoreIn ? laneWdata : 32'h0;
              req_wstrb_q <= isStoreIn ? laneWstrb : 4'b0000;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state_q     <= WAIT_RSP;
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        WAIT_RSP: begin
          if (bus.mem_rsp_valid) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_err_q   <= bus.mem_rsp_err;
            out_cause_q <= rsp_cause_d;
            out_rdata_q <= rsp_rdata_d;
          end else if (timeoutHit) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b1;
            out_cause_q <= CAUSE_ACCESS_FAULT;
            out_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rdata     = out_rdata_q;
  assign bus.out_sb        = sb_q;
  assign bus.out_err       = out_err_q;
  assign bus.out_cause     = out_cause_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wstrb = req_wstrb_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: directed instructions push expected
// requests/results; a memory model and a WBU monitor pop and compare.
module tb_lsu_bus_ctrl;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
    logic [15:0] sb;
  } exp_out_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_req_t;

  logic clk;
  logic rst;

  int assertions = 0;
  int failures   = 0;

  exp_out_t expQ[$];
  exp_req_t reqQ[$];

  int          memDelay   = 0;
  int          memRspWait = 0;
  bit          memNoRsp   = 0;
  bit          memLate    = 0;
  bit          memErr     = 0;
  logic [31:0] memRdata   = 32'h0;
  int          wbuHoldCfg = 0;

  lsu_bus_ctrl_if #(.SB_W(16)) bus ();

  lsu_bus_ctrl #(
    .SB_W        (16),
    .TIMEOUT_CYC (8),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic exp_req_t mkReq(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] ws);
    exp_req_t r;
    r.addr = a; r.we = we; r.wdata = wd; r.wstrb = ws;
    return r;
  endfunction

  function automatic exp_out_t mkOut(input logic [31:0] rd, input logic err, input logic [1:0] cause, input logic [15:0] sb);
    exp_out_t o;
    o.rdata = rd; o.err = err; o.cause = cause; o.sb = sb;
    return o;
  endfunction

  task automatic checkReq(input exp_req_t r);
    checkOutput("req_addr", bus.mem_req_addr, r.addr);
    checkOutput("req_we", 32'(bus.mem_req_we), 32'(r.we));
    checkOutput("req_wstrb", 32'(bus.mem_req_wstrb), 32'(r.wstrb));
    if (r.we) checkOutput("req_wdata", bus.mem_req_wdata, r.wdata);
  endtask

  // Memory model: checks request fields while stalled, then responds
  initial begin : memModel
    exp_req_t r;
    bit aborted;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'h0;
    bus.mem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_err   = 1'b0;
      if (bus.mem_req_valid && rst) begin
        if (reqQ.size() == 0) begin
          checkOutput("mem_req_valid (none expected)", 32'(bus.mem_req_valid), 32'h0);
          bus.mem_req_ready = 1'b1;
          @(negedge clk);
          bus.mem_req_ready = 1'b0;
        end else begin
          r = reqQ.pop_front();
          aborted = 1'b0;
          for (int k = 0; k < memDelay; k++) begin
            checkReq(r);
            if (k == 0 && memLate) begin
              bus.mem_rsp_valid = 1'b1;
              bus.mem_rsp_rdata = 32'hBAD0_BAD0;
              bus.mem_rsp_err   = 1'b1;
            end
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_err   = 1'b0;
            if (!bus.mem_req_valid) begin
              aborted = 1'b1;
              break;
            end
          end
          if (!aborted) begin
            checkReq(r);
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            if (!memNoRsp) begin
              repeat (memRspWait) @(negedge clk);
              bus.mem_rsp_valid = 1'b1;
              bus.mem_rsp_rdata = memRdata;
              bus.mem_rsp_err   = memErr;
              @(negedge clk);
              bus.mem_rsp_valid = 1'b0;
              bus.mem_rsp_err   = 1'b0;
            end
          end
        end
      end
    end
  end

  // WBU monitor: compares every presented result, applies out_ready backpressure
  initial begin : wbuMonitor
    int hold;
    exp_out_t e;
    hold = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("out_valid (none expected)", 32'(bus.out_valid), 32'h0);
          bus.out_ready = 1'b1;
        end else begin
          e = expQ[0];
          checkOutput("out_rdata", bus.out_rdata, e.rdata);
          checkOutput("out_err", 32'(bus.out_err), 32'(e.err));
          checkOutput("out_cause", 32'(bus.out_cause), 32'(e.cause));
          checkOutput("out_sb", 32'(bus.out_sb), 32'(e.sb));
          if (hold > 0) begin
            hold--;
          end else begin
            bus.out_ready = 1'b1;
            void'(expQ.pop_front());
          end
        end
      end else begin
        bus.out_ready = 1'b0;
        hold = wbuHoldCfg;
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] f3, input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [15:0] sb);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("in_ready before issue", 32'(bus.in_ready), 32'h1);
    bus.in_valid   = 1'b1;
    bus.in_mem_ren = ren;
    bus.in_mem_wen = wen;
    bus.in_func3   = f3;
    bus.in_addr    = addr;
    bus.in_wdata   = wdata;
    bus.in_sb      = sb;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.in_mem_ren = 1'b0;
    bus.in_mem_wen = 1'b0;
  endtask

  task automatic runTxn(input logic [2:0] f3, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [15:0] sb,
                        input bit expReq, input exp_req_t rq, input exp_out_t eo, input int expLat);
    int lat;
    bit seenValid, reqSeen, inReadyBad, done;
    if (expReq) reqQ.push_back(rq);
    expQ.push_back(eo);
    applyStimulus(f3, ren, wen, addr, wdata, sb);
    lat = 0; seenValid = 0; reqSeen = 0; inReadyBad = 0; done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!seenValid) lat++;
      if (bus.mem_req_valid) reqSeen = 1'b1;
      if (bus.out_valid) seenValid = 1'b1;
      else if (seenValid) done = 1'b1;
      if (!done && bus.in_ready) inReadyBad = 1'b1;
    end
    checkOutput("transaction completed", 32'(done), 32'h1);
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("request issued", 32'(reqSeen), 32'(expReq));
    checkOutput("in_ready low while busy", 32'(inReadyBad), 32'h0);
    checkOutput("in_ready after handshake", 32'(bus.in_ready), 32'h1);
  endtask

  // Directed test sequence
  initial begin : mainSeq
    exp_req_t noReq;
    noReq = mkReq(32'h0, 1'b0, 32'h0, 4'h0);
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_mem_ren = 1'b0; bus.in_mem_wen = 1'b0;
    bus.in_func3 = 3'b0; bus.in_addr = 32'h0; bus.in_wdata = 32'h0; bus.in_sb = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'h1);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset mem_req_valid", 32'(bus.mem_req_valid), 32'h0);
    checkOutput("reset out_rdata", bus.out_rdata, 32'h0);
    checkOutput("reset out_err", 32'(bus.out_err), 32'h0);
    checkOutput("reset out_sb", 32'(bus.out_sb), 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;

    memRdata = 32'h80FF_1234;
    runTxn(F3_LB, 1, 0, 32'h8000_0003, 32'hDEAD_BEEF, 16'hA001, 1,
           mkReq(32'h8000_0000, 0, 32'h0, 4'b0000), mkOut(32'hFFFF_FF80, 0, CAUSE_NONE, 16'hA001), 3);
    memRdata = 32'h1234_5678;
    runTxn(F3_SH, 0, 1, 32'h8000_0002, 32'h0000_ABCD, 16'hA002, 1,
           mkReq(32'h8000_0000, 1, 32'hABCD_ABCD, 4'b1100), mkOut(32'h0, 0, CAUSE_NONE, 16'hA002), 3);
    runTxn(F3_LW, 1, 0, 32'h8000_0001, 32'h0, 16'hA003, 0, noReq,
           mkOut(32'h0, 1, CAUSE_LD_MISALIGN, 16'hA003), 1);
    runTxn(F3_SW, 0, 1, 32'h8000_0002, 32'h5555_5555, 16'hA004, 0, noReq,
           mkOut(32'h0, 1, CAUSE_ST_MISALIGN, 16'hA004), 1);
    runTxn(F3_SH, 0, 1, 32'h8000_0001, 32'h5555_5555, 16'hA005, 0, noReq,
           mkOut(32'h0, 1, CAUSE_ST_MISALIGN, 16'hA005), 1);
    runTxn(F3_LW, 0, 0, 32'h8000_0001, 32'h0, 16'hA006, 0, noReq,
           mkOut(32'h0, 0, CAUSE_NONE, 16'hA006), 1);
    runTxn(F3_SB, 1, 1, 32'h8000_0001, 32'h1234_56A5, 16'hA007, 1,
           mkReq(32'h8000_0000, 1, 32'hA5A5_A5A5, 4'b0010), mkOut(32'h0, 0, CAUSE_NONE, 16'hA007), 3);
    memRdata = 32'h8001_7FFF;
    runTxn(F3_LH, 1, 0, 32'h8000_0002, 32'h0, 16'hA008, 1,
           mkReq(32'h8000_0000, 0, 32'h0, 4'b0000), mkOut(32'hFFFF_8001, 0, CAUSE_NONE, 16'hA008), 3);
    memRdata = 32'h7FFF_8001;
    runTxn(F3_LHU, 1, 0, 32'h8000_0000, 32'h0, 16'hA009, 1,
           mkReq(32'h8000_0000, 0, 32'h0, 4'b0000), mkOut(32'h0000_8001, 0, CAUSE_NONE, 16'hA009), 3);

    memDelay = 5; wbuHoldCfg = 4; memRdata = 32'hCAFE_F00D;
    runTxn(F3_LW, 1, 0, 32'h8000_0004, 32'h0, 16'hA00A, 1,
           mkReq(32'h8000_0004, 0, 32'h0, 4'b0000), mkOut(32'hCAFE_F00D, 0, CAUSE_NONE, 16'hA00A), 8);
    memDelay = 0; wbuHoldCfg = 0;

    memNoRsp = 1;
    runTxn(F3_LW, 1, 0, 32'h8000_0008, 32'h0, 16'hA00B, 1,
           mkReq(32'h8000_0008, 0, 32'h0, 4'b0000), mkOut(32'h0, 1, CAUSE_ACCESS_FAULT, 16'hA00B), 10);
    memNoRsp = 0; memLate = 1; memDelay = 2; memRdata = 32'h1122_3344;
    runTxn(F3_LW, 1, 0, 32'h8000_0010, 32'h0, 16'hA00C, 1,
           mkReq(32'h8000_0010, 0, 32'h0, 4'b0000), mkOut(32'h1122_3344, 0, CAUSE_NONE, 16'hA00C), 5);
    memLate = 0; memDelay = 0; memRspWait = 7; memRdata = 32'h0BAD_CAFE;
    runTxn(F3_LW, 1, 0, 32'h8000_000C, 32'h0, 16'hA00D, 1,
           mkReq(32'h8000_000C, 0, 32'h0, 4'b0000), mkOut(32'h0BAD_CAFE, 0, CAUSE_NONE, 16'hA00D), 10);
    memRspWait = 0; memErr = 1; memRdata = 32'hFFFF_FFFF;
    runTxn(F3_LW, 1, 0, 32'h8000_0014, 32'h0, 16'hA00E, 1,
           mkReq(32'h8000_0014, 0, 32'h0, 4'b0000), mkOut(32'h0, 1, CAUSE_ACCESS_FAULT, 16'hA00E), 3);
    memErr = 0;

    memDelay = 20;
    reqQ.push_back(mkReq(32'h8000_001C, 0, 32'h0, 4'b0000));
    applyStimulus(F3_LW, 1, 0, 32'h8000_001C, 32'h0, 16'hA00F);
    repeat (2) @(negedge clk);
    #2;
    checkOutput("mem_req_valid before reset", 32'(bus.mem_req_valid), 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("mem_req_valid async drop", 32'(bus.mem_req_valid), 32'h0);
    checkOutput("in_ready during reset", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    memDelay = 0;

    memNoRsp = 1;
    reqQ.push_back(mkReq(32'h8000_0018, 0, 32'h0, 4'b0000));
    applyStimulus(F3_LW, 1, 0, 32'h8000_0018, 32'h0, 16'hA010);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("out_valid during reset", 32'(bus.out_valid), 32'h0);
    checkOutput("mem_req_valid during reset", 32'(bus.mem_req_valid), 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("in_ready after reset", 32'(bus.in_ready), 32'h1);
    memNoRsp = 0; memRdata = 32'h0000_F000;
    runTxn(F3_LBU, 1, 0, 32'h8000_0001, 32'h0, 16'hA011, 1,
           mkReq(32'h8000_0000, 0, 32'h0, 4'b0000), mkOut(32'h0000_00F0, 0, CAUSE_NONE, 16'hA011), 3);

    repeat (3) @(negedge clk);
    checkOutput("results left unchecked", 32'(expQ.size()), 32'h0);
    checkOutput("requests left unissued", 32'(reqQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  // Global time limit so a wedged run still ends
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] time limit");
  end

endmodule
